// File: rtl/safe_keypad_frontend.sv
// safe_keypad_frontend
// Cleans up the four raw safe-lock buttons (A..D) and turns each single-button
// press into exactly one key pulse plus an encoded key code. Simultaneous
// presses are rejected with a multi_err pulse. press_count tracks the
// position inside a four-key entry.
//
// Optional feature, enabled by defining the macro ENTRY_TIMEOUT_EN:
//   a stale partial entry is abandoned after TIMEOUT_CYCLES idle cycles
//   (entry_clear pulses and press_count returns to 0). Without the macro
//   entry_clear is constant 0.
module safe_keypad_frontend #(
    parameter int DEBOUNCE_CYCLES = 270_000,
    parameter int TIMEOUT_CYCLES  = 135_000_000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] btn_raw,
    output logic       key_a,
    output logic       key_b,
    output logic       key_c,
    output logic       key_d,
    output logic       key_valid,
    output logic [1:0] key_code,
    output logic       multi_err,
    output logic [2:0] press_count,
    output logic       entry_clear
);

    // Both counts are measured in cycles and must allow at least one step.
    if (DEBOUNCE_CYCLES < 2 || TIMEOUT_CYCLES < 2) begin : g_bad_params
        $error("safe_keypad_frontend: DEBOUNCE_CYCLES and TIMEOUT_CYCLES must be at least 2");
    end

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HELD = 1'b1
    } state_t;

    // Number of set bits in a 4-bit vector.
    function automatic logic [2:0] count_ones(input logic [3:0] v);
        count_ones = {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

    // Index of the single set bit of a one-hot vector.
    function automatic logic [1:0] encode_key(input logic [3:0] v);
        case (v)
            4'b0001: encode_key = 2'd0;
            4'b0010: encode_key = 2'd1;
            4'b0100: encode_key = 2'd2;
            4'b1000: encode_key = 2'd3;
            default: encode_key = 2'd0;
        endcase
    endfunction

    logic [3:0]    sync1_r;
    logic [3:0]    sync2_r;
    logic [CW-1:0] db_cnt_r [4];
    logic [3:0]    deb_r;
    logic [3:0]    deb_prev_r;
    logic [3:0]    rise_s;

    state_t        state_r;
    state_t        state_s;
    logic [3:0]    key_s;
    logic          key_valid_s;
    logic          multi_s;
    logic [1:0]    code_s;
    logic          timeout_s;

    logic [3:0]    key_r;
    logic          key_valid_r;
    logic [1:0]    key_code_r;
    logic          multi_err_r;
    logic [2:0]    press_count_r;
    logic          entry_clear_r;

    // Two-flop synchroniser for the asynchronous button inputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_r <= 4'b0000;
            sync2_r <= 4'b0000;
        end else begin
            sync1_r <= btn_raw;
            sync2_r <= sync1_r;
        end
    end

    // Per-bit debounce: flip only after DEBOUNCE_CYCLES consecutive mismatches.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) begin
                db_cnt_r[i] <= '0;
            end
            deb_r      <= 4'b0000;
            deb_prev_r <= 4'b0000;
        end else begin
            deb_prev_r <= deb_r;
            for (int i = 0; i < 4; i++) begin
                if (sync2_r[i] == deb_r[i]) begin
                    db_cnt_r[i] <= '0;
                end else if (db_cnt_r[i] == DB_LAST) begin
                    deb_r[i]    <= ~deb_r[i];
                    db_cnt_r[i] <= '0;
                end else begin
                    db_cnt_r[i] <= db_cnt_r[i] + CW'(1);
                end
            end
        end
    end

    assign rise_s = deb_r & ~deb_prev_r;

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next state and next output values; one press per hold, release re-arms.
    always_comb begin
        state_s     = state_r;
        key_s       = 4'b0000;
        key_valid_s = 1'b0;
        multi_s     = 1'b0;
        code_s      = key_code_r;
        case (state_r)
            ST_IDLE: begin
                if ((count_ones(rise_s) == 3'd1) && ((deb_r & ~rise_s) == 4'b0000)) begin
                    key_s       = rise_s;
                    key_valid_s = 1'b1;
                    code_s      = encode_key(rise_s);
                    state_s     = ST_HELD;
                end else if (rise_s != 4'b0000) begin
                    // Several buttons (or a button alongside one already down).
                    multi_s = 1'b1;
                    state_s = ST_HELD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_HELD: begin
                if (deb_r == 4'b0000) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_HELD;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

`ifdef ENTRY_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] timer_r;

    // A key in the same cycle as the timeout wins, so the entry survives.
    assign timeout_s = (press_count_r != 3'd0) && (timer_r == TO_LAST) && !key_valid_s;

    // Idle timer: runs while an entry is partial, restarts on every key.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timer_r <= '0;
        end else if (key_valid_s) begin
            timer_r <= '0;
        end else if ((press_count_r != 3'd0) && (timer_r != TO_LAST)) begin
            timer_r <= timer_r + TW'(1);
        end else begin
            timer_r <= '0;
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // Registered outputs and entry position (wraps 3 -> 0 on the fourth key).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_r         <= 4'b0000;
            key_valid_r   <= 1'b0;
            key_code_r    <= 2'd0;
            multi_err_r   <= 1'b0;
            entry_clear_r <= 1'b0;
            press_count_r <= 3'd0;
        end else begin
            key_r         <= key_s;
            key_valid_r   <= key_valid_s;
            key_code_r    <= code_s;
            multi_err_r   <= multi_s;
            entry_clear_r <= timeout_s;
            if (key_valid_s) begin
                press_count_r <= (press_count_r == 3'd3) ? 3'd0 : press_count_r + 3'd1;
            end else if (timeout_s) begin
                press_count_r <= 3'd0;
            end else begin
                press_count_r <= press_count_r;
            end
        end
    end

    assign key_a       = key_r[0];
    assign key_b       = key_r[1];
    assign key_c       = key_r[2];
    assign key_d       = key_r[3];
    assign key_valid   = key_valid_r;
    assign key_code    = key_code_r;
    assign multi_err   = multi_err_r;
    assign press_count = press_count_r;
    assign entry_clear = entry_clear_r;

endmodule

// File: tb/tb_safe_keypad_frontend.sv
// Testbench for safe_keypad_frontend (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=50).
// The driver advances a behavioural model one clock at a time and queues the
// expected output events; an independent monitor pops and compares them.
module tb_safe_keypad_frontend;

    localparam int DB = 4;
    localparam int TO = 50;

    logic       clk;
    logic       reset_n;
    logic [3:0] btn_raw;
    logic       key_a, key_b, key_c, key_d;
    logic       key_valid;
    logic [1:0] key_code;
    logic       multi_err;
    logic [2:0] press_count;
    logic       entry_clear;

    safe_keypad_frontend #(
        .DEBOUNCE_CYCLES(DB),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .btn_raw    (btn_raw),
        .key_a      (key_a),
        .key_b      (key_b),
        .key_c      (key_c),
        .key_d      (key_d),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .multi_err  (multi_err),
        .press_count(press_count),
        .entry_clear(entry_clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [3:0] key;
        logic       multi;
        logic       clear;
        logic [1:0] code;
        logic [2:0] count;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc;

    // ---------------- reference model state ----------------
    int         m_edge;
    logic [3:0] m_s1, m_s2;
    logic [3:0] m_win [DB];
    logic [3:0] m_deb, m_deb_prev;
    bit         m_held;
    int         m_count;
    int         m_timer;
    logic [1:0] m_code;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    task automatic model_reset();
        m_edge = 0; m_s1 = 4'b0000; m_s2 = 4'b0000;
        for (int k = 0; k < DB; k++) m_win[k] = 4'b0000;
        m_deb = 4'b0000; m_deb_prev = 4'b0000;
        m_held = 0; m_count = 0; m_timer = 0; m_code = 2'd0;
    endtask

    // Apply b for the next clock edge, predict that edge, move to the next negedge.
    task automatic step(input logic [3:0] b);
        logic [3:0] rise;
        logic [3:0] nd;
        bit         key_ev, all_diff;
        exp_t       e;
        m_edge++;
        btn_raw = b;
        rise    = m_deb & ~m_deb_prev;
        e.cyc = m_edge; e.key = 4'b0000; e.multi = 1'b0; e.clear = 1'b0;
        key_ev = 0;
        if (!m_held) begin
            if ($countones(rise) == 1 && (m_deb & ~rise) == 4'b0000) begin
                e.key  = rise;
                key_ev = 1;
                for (int i = 0; i < 4; i++) if (rise[i]) m_code = 2'(i);
                m_held = 1;
            end else if (rise != 4'b0000) begin
                e.multi = 1'b1;
                m_held  = 1;
            end
        end else if (m_deb == 4'b0000) begin
            m_held = 0;
        end
        if (key_ev) begin
            m_count = (m_count + 1) % 4;
            m_timer = 0;
        end else if (m_count != 0) begin
`ifdef ENTRY_TIMEOUT_EN
            if (m_timer == TO - 1) begin
                e.clear = 1'b1;
                m_count = 0;
                m_timer = 0;
            end else begin
                m_timer++;
            end
`endif
        end
        e.code  = m_code;
        e.count = 3'(m_count);
        if (key_ev || e.multi || e.clear) exp_q.push_back(e);
        // A level is accepted once the last DB synchronised samples all disagree with it.
        for (int k = DB - 1; k > 0; k--) m_win[k] = m_win[k-1];
        m_win[0] = m_s2;
        nd = m_deb;
        for (int i = 0; i < 4; i++) begin
            all_diff = 1;
            for (int k = 0; k < DB; k++) if (m_win[k][i] == m_deb[i]) all_diff = 0;
            if (all_diff) nd[i] = ~m_deb[i];
        end
        m_deb_prev = m_deb;
        m_deb      = nd;
        m_s2       = m_s1;
        m_s1       = b;
        @(negedge clk);
    endtask

    task automatic hold(input logic [3:0] b, input int n);
        repeat (n) step(b);
    endtask

    task automatic do_reset(input logic [3:0] b);
        reset_n = 1'b0;
        btn_raw = b;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({key_a, key_b, key_c, key_d, key_valid, key_code, multi_err, press_count, entry_clear} != 13'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got keys=%b valid=%b code=%0d multi=%b cnt=%0d clr=%b, required all 0",
                     {key_d, key_c, key_b, key_a}, key_valid, key_code, multi_err, press_count, entry_clear);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL pending_at_reset: %0d expected events never seen, required 0", exp_q.size());
        end
        exp_q.delete();
        model_reset();
        reset_n = 1'b1;
    endtask

    // Monitor: checks pulse shape every cycle and matches output events to the queue.
    initial begin : monitor
        logic [3:0] keys;
        logic       prev_valid;
        exp_t       e;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                keys = {key_d, key_c, key_b, key_a};
                n_checks++;
                if (key_valid !== (|keys) || (key_valid && prev_valid) || $countones(keys) > 1) begin
                    n_fail++;
                    $display("FAIL pulse_shape cyc=%0d: valid=%b keys=%b prev_valid=%b, required one-hot single-cycle pulse",
                             cyc, key_valid, keys, prev_valid);
                end
                prev_valid = key_valid;
                while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                    e = exp_q.pop_front();
                    n_checks++;
                    n_fail++;
                    $display("FAIL missing_event: nothing at cyc %0d, required key=%b multi=%b clr=%b",
                             e.cyc, e.key, e.multi, e.clear);
                end
                if (key_valid || multi_err || entry_clear) begin
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_event cyc=%0d: keys=%b multi=%b clr=%b, required none",
                                 cyc, keys, multi_err, entry_clear);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.cyc != cyc || e.key !== keys || e.multi !== multi_err || e.clear !== entry_clear ||
                            e.code !== key_code || e.count !== press_count) begin
                            n_fail++;
                            $display("FAIL event: got cyc=%0d keys=%b multi=%b clr=%b code=%0d cnt=%0d, required cyc=%0d keys=%b multi=%b clr=%b code=%0d cnt=%0d",
                                     cyc, keys, multi_err, entry_clear, key_code, press_count,
                                     e.cyc, e.key, e.multi, e.clear, e.code, e.count);
                        end
                    end
                end
            end else begin
                prev_valid = 1'b0;
            end
        end
    end

    initial begin : driver
        logic [3:0] pat;
        logic [3:0] prev_pat;
        int         r, len;
        reset_n = 1'b1;
        btn_raw = 4'b0000;
        model_reset();
        #1;
        // Reset with every button held: outputs 0, then one multi_err after debounce.
        do_reset(4'b1111);
        hold(4'b1111, 20);
        hold(4'b0000, 20);
        // Clean press of B.
        hold(4'b0010, 20);
        hold(4'b0000, 20);
        // Bouncing A: 2-cycle runs never pass the debouncer.
        repeat (4) begin
            hold(4'b0001, 2);
            hold(4'b0000, 2);
        end
        hold(4'b0000, 20);
        // A and C together, then A held before C.
        hold(4'b0101, 15);
        hold(4'b0000, 20);
        hold(4'b0001, 5);
        hold(4'b0101, 15);
        hold(4'b0000, 20);
        // Fresh entry: B, D, A, C.
        do_reset(4'b0000);
        hold(4'b0000, 5);
        hold(4'b0010, 10); hold(4'b0000, 10);
        hold(4'b1000, 10); hold(4'b0000, 10);
        hold(4'b0001, 10); hold(4'b0000, 10);
        hold(4'b0100, 10); hold(4'b0000, 10);
        hold(4'b0000, 20);
        // One key then a long idle.
        hold(4'b0010, 10);
        hold(4'b0000, 60);
        n_checks++;
`ifdef ENTRY_TIMEOUT_EN
        if (press_count !== 3'd0) begin
            n_fail++;
            $display("FAIL timeout_count: got %0d, required 0", press_count);
        end
`else
        if (press_count !== 3'd1) begin
            n_fail++;
            $display("FAIL no_timeout_count: got %0d, required 1", press_count);
        end
`endif
        // Reset while A is held: A is debounced afresh and produces one pulse.
        hold(4'b0000, 10);
        hold(4'b0001, 20);
        do_reset(4'b0001);
        hold(4'b0001, 20);
        hold(4'b0000, 20);
        // Randomised segments.
        prev_pat = 4'b0000;
        for (int s = 0; s < 250; s++) begin
            r   = $urandom_range(0, 9);
            len = $urandom_range(1, 14);
            if (r <= 5)      pat = 4'(1 << $urandom_range(0, 3));
            else if (r == 6) pat = 4'b0000;
            else if (r == 7) begin pat = 4'b0000; len = $urandom_range(40, 70); end
            else if (r == 8) pat = 4'($urandom_range(0, 15));
            else             pat = prev_pat | 4'(1 << $urandom_range(0, 3));
            hold(pat, len);
            prev_pat = pat;
        end
        hold(4'b0000, 80);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected events never seen, required 0", exp_q.size());
        end
        n_checks++;
        if (press_count !== 3'(m_count)) begin
            n_fail++;
            $display("FAIL final_count: got %0d, required %0d", press_count, m_count);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/safe_keypad_frontend.md
# safe_keypad_frontend

Debounces the four raw safe-lock push buttons (A, B, C, D) and turns each clean, single-button press into a one-cycle key pulse plus an encoded key code. It sits between the board pins and the combination-lock FSM, which counts every cycle any key input is high and therefore requires exactly one pulse per physical press. It also tracks entry position and can optionally abandon a stale partial entry.

## Interface
- DEBOUNCE_CYCLES, 270_000, consecutive stable cycles required to accept a level change (10 ms at 27 MHz); minimum 2.
- TIMEOUT_CYCLES, 135_000_000, idle cycles after the last key before a partial entry is cleared (5 s at 27 MHz); used only with ENTRY_TIMEOUT_EN.
- clk  in  1  system clock, 27 MHz nominal.
- reset_n  in  1  asynchronous active-low reset.
- btn_raw  in  4  raw buttons, bit0=A, bit1=B, bit2=C, bit3=D; active-high, asynchronous to clk.
- key_a, key_b, key_c, key_d  out  1 each  one-cycle press pulses.
- key_valid  out  1  high in the same cycle as any key_* pulse.
- key_code  out  2  index of the pressed key (A=0 … D=3); holds its last value between pulses.
- multi_err  out  1  one-cycle pulse when a press is rejected as a multi-button press.
- press_count  out  3  keys accepted in the current entry, 0..3.
- entry_clear  out  1  one-cycle pulse when a partial entry is abandoned on timeout.

## Operation
- Synchroniser: two flops per bit, reset to 0.
- Debounce, per bit: a counter runs while the synchronised level differs from the debounced level and resets to 0 whenever they match. When the count reaches DEBOUNCE_CYCLES-1, the debounced level flips and the counter clears. The counter width is ceil(log2(DEBOUNCE_CYCLES)).
- Press event: a 0→1 transition of a debounced bit. Release: all four debounced bits are 0.
- FSM, two states:
  - IDLE, on exactly one press event with no other debounced bit high: emit key_* and key_valid, load key_code, then go to HELD.
  - IDLE, on more than one press event in the same cycle: emit the multi_err pulse, no key pulse, go to HELD.
  - HELD: all press events are ignored, so a second button pressed while the first is held produces nothing. Return to IDLE the cycle after release.
- press_count: increments on each key_valid and wraps 3→0 on the 4th key, matching the lock's four-key grouping.
- Reset mid-press: all state returns to reset values. A button still held after reset_n deasserts is debounced afresh and produces one pulse.
- Reset values: all outputs 0. FSM in IDLE. Debounced levels, counters and the timeout timer all 0.

## Timing
- All outputs are registered.
- Latency: btn_raw goes high and stays stable before clk edge E0. key_* is high for exactly the one cycle following edge E0+DEBOUNCE_CYCLES+2: 2 cycles for the synchroniser, DEBOUNCE_CYCLES for debounce, 1 for the output register.
- Glitches shorter than DEBOUNCE_CYCLES cycles (measured at the synchroniser output) never change the debounced level.
- Release is debounced the same way. A new press is accepted at the earliest one cycle after the FSM returns to IDLE.
- key_valid and key_* are never high for two consecutive cycles.

## Configuration
- Macro: ENTRY_TIMEOUT_EN.
- Defined:
  - A timer counts cycles while press_count≠0 and restarts at 0 on every key_valid.
  - When it reaches TIMEOUT_CYCLES-1: entry_clear pulses for one cycle, press_count returns to 0, the timer clears.
  - If key_valid occurs in the same cycle as the timeout, key_valid wins: no clear, and press_count increments.
- Undefined: no timer logic; entry_clear is tied to 0; press_count only changes through key_valid.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and TIMEOUT_CYCLES=50.
- Reset: hold reset_n low with btn_raw=4'b1111 -> all outputs 0; after release, key_*, key_valid and multi_err stay 0 for the 6 cycles following the first edge.
- Clean press: btn_raw=4'b0010 held 20 cycles, then 0 -> key_b pulses exactly once, at cycle E0+6; key_code=1; press_count=1.
- Bounce: btn_raw toggles 0/1 every 2 cycles for 16 cycles, then stays 0 -> no pulse at all.
- Multi-press:
  - A and C rise on the same cycle -> multi_err pulses once, no key pulse, press_count unchanged.
  - A held, then C pressed -> one key_a pulse only.
- Sequence B, D, A, C, each held 10 cycles with 10 released -> four single pulses, key_code 1, 3, 0, 2; press_count 1, 2, 3, 0.
- Timeout (ENTRY_TIMEOUT_EN): press B, then idle 60 cycles -> entry_clear pulses once, 50 cycles after key_valid; press_count returns to 0. Without the macro, entry_clear stays 0 and press_count stays 1.
